// File: rtl/aes_pkg.sv
// Shared constants for the AES self-test sequencer: mode codes, round counts,
// FIPS-197 known-answer vectors and the run-control state encoding.
package aes_pkg;

  localparam int ROUND_W = 5;

  localparam logic [1:0] MODE_128 = 2'b00;
  localparam logic [1:0] MODE_192 = 2'b01;
  localparam logic [1:0] MODE_256 = 2'b10;
  localparam logic [1:0] MODE_BAD = 2'b11;

  localparam logic [ROUND_W-1:0] NR_128 = 5'd10;
  localparam logic [ROUND_W-1:0] NR_192 = 5'd12;
  localparam logic [ROUND_W-1:0] NR_256 = 5'd14;

  localparam logic [127:0] PT         = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EXP_CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] EXP_CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] EXP_CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ENC,
    S_DEC,
    S_DONE
  } state_t;

  function automatic logic [ROUND_W-1:0] nr_of(input logic [1:0] m);
    case (m)
      MODE_192: nr_of = NR_192;
      MODE_256: nr_of = NR_256;
      default:  nr_of = NR_128;
    endcase
  endfunction

  function automatic logic [127:0] exp_ct_of(input logic [1:0] m);
    case (m)
      MODE_192: exp_ct_of = EXP_CT_192;
      MODE_256: exp_ct_of = EXP_CT_256;
      default:  exp_ct_of = EXP_CT_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_phase_counter.sv
// Round counter shared by the encrypt and decrypt phases; saturates at the
// programmed round count and flags the terminal round.
module aes_phase_counter
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_inc,
  input  logic [ROUND_W-1:0] i_nr,
  output logic [ROUND_W-1:0] o_count,
  output logic               o_term
);

  logic [ROUND_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != i_nr)) begin
      r_count <= r_count + ROUND_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_term  = (r_count == i_nr);

endmodule

// File: rtl/aes_selftest_sequencer.sv
// Run-control FSM: clears the cores, steps the forward then inverse core for
// the latched key size, and checks both final states against known answers.
module aes_selftest_sequencer
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [127:0]       core_out,
  output logic [5:0]         core_en,
  output logic               core_clr,
  output logic [ROUND_W-1:0] round_num,
  output logic [127:0]       display_state,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               err
);

  state_t             r_state;
  state_t             w_stateNext;
  logic [1:0]         r_mode;
  logic               r_encOk;
  logic               r_pass;
  logic               r_err;
  logic               r_errDone;
  logic [127:0]       r_disp;
  logic [ROUND_W-1:0] w_nr;
  logic [ROUND_W-1:0] w_count;
  logic               w_term;
  logic               w_accept;
  logic               w_reject;
  logic               w_decOk;
  logic [5:0]         w_encEn;
  logic [5:0]         w_coreEn;
  logic               w_coreClr;
  logic               w_busy;
  logic               w_done;
  logic               w_cntClr;
  logic               w_cntInc;

  assign w_nr     = nr_of(r_mode);
  assign w_accept = (r_state == S_IDLE) && start && (mode != MODE_BAD);
  assign w_reject = (r_state == S_IDLE) && start && (mode == MODE_BAD);
  assign w_decOk  = (core_out == PT);
  assign w_encEn  = 6'b000001 << {r_mode, 1'b0};

  aes_phase_counter u_counter (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_cntClr),
    .i_inc   (w_cntInc),
    .i_nr    (w_nr),
    .o_count (w_count),
    .o_term  (w_term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Counter is cleared on every exit to IDLE so round_num reads 0 whenever idle.
  always_comb begin
    w_stateNext = r_state;
    w_coreEn    = '0;
    w_coreClr   = 1'b0;
    w_busy      = 1'b0;
    w_done      = r_errDone;
    w_cntClr    = 1'b0;
    w_cntInc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_stateNext = S_CLEAR;
      end
      S_CLEAR: begin
        w_busy      = 1'b1;
        w_coreClr   = 1'b1;
        w_cntClr    = 1'b1;
        w_stateNext = S_ENC;
      end
      S_ENC: begin
        w_busy   = 1'b1;
        w_coreEn = w_encEn;
        w_cntInc = 1'b1;
        if (w_term) begin
          w_cntClr    = 1'b1;
          w_stateNext = S_DEC;
        end
      end
      S_DEC: begin
        w_busy   = 1'b1;
        w_coreEn = w_encEn << 1;
        w_cntInc = 1'b1;
        if (w_term) w_stateNext = S_DONE;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_cntClr    = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_cntClr    = 1'b1;
      w_stateNext = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode    <= MODE_128;
      r_encOk   <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= 1'b0;
      r_errDone <= 1'b0;
      r_disp    <= '0;
    end else begin
      r_errDone <= w_reject;
      if (w_accept) begin
        r_mode  <= mode;
        r_encOk <= 1'b0;
        r_pass  <= 1'b0;
        r_err   <= 1'b0;
      end
      if (w_reject) r_err <= 1'b1;
      if ((r_state == S_ENC) || (r_state == S_DEC)) r_disp <= core_out;
      if ((r_state == S_ENC) && w_term) r_encOk <= (core_out == exp_ct_of(r_mode));
      // Pass is resolved on the last DEC round so it is already valid alongside done.
      if ((r_state == S_DEC) && w_term && !abort) r_pass <= r_encOk && w_decOk;
    end
  end

  assign core_en       = w_coreEn;
  assign core_clr      = w_coreClr;
  assign round_num     = w_count;
  assign display_state = r_disp;
  assign busy          = w_busy;
  assign done          = w_done;
  assign pass          = r_pass;
  assign err           = r_err;

  a_coreEnOneHot: assert property (@(posedge clk) disable iff (!reset) $onehot0(core_en));

endmodule

// File: tb/tb_aes_selftest_sequencer.sv
// Self-checking bench for aes_selftest_sequencer: a schedule-based core model
// feeds core_out and every output is compared against expected run timing.
module tb_aes_selftest_sequencer;

  logic         clk;
  logic         reset;
  logic         start;
  logic         abort;
  logic [1:0]   mode;
  logic [127:0] core_out;
  logic [5:0]   core_en;
  logic         core_clr;
  logic [4:0]   round_num;
  logic [127:0] display_state;
  logic         busy;
  logic         done;
  logic         pass;
  logic         err;

  int           checks;
  int           errors;
  logic [127:0] lastDisp;
  logic         lastPass;

  localparam logic [127:0] TB_PT = 128'h00112233445566778899aabbccddeeff;

  aes_selftest_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .mode          (mode),
    .core_out      (core_out),
    .core_en       (core_en),
    .core_clr      (core_clr),
    .round_num     (round_num),
    .display_state (display_state),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err           (err)
  );

  // Free-running 10-time-unit clock; the bench acts on falling edges only.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete run, cycle 0 being the cycle in which start is presented.
  // abortAt: -1 none, 0 together with start, >0 during that busy cycle.
  // corrupt: 0 none, 1 flip ciphertext LSB, 2 flip recovered plaintext LSB.
  task automatic runSequence(input logic [1:0] m, input int corrupt, input int abortAt,
                             input int extraStartAt, input int modeChgAt,
                             input logic [1:0] modeChgVal, input string tag);
    int           n;
    int           sh;
    int           expRn;
    logic [127:0] ct;
    logic [127:0] drv;
    logic [5:0]   expEn;
    logic         encOk;
    logic         decOk;
    logic         expPass;
    n  = (m == 2'b00) ? 10 : (m == 2'b01) ? 12 : 14;
    ct = (m == 2'b00) ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a :
         (m == 2'b01) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                        128'h8ea2b7ca516745bfeafc49904b496089;
    encOk = 1'b0;
    decOk = 1'b0;
    @(negedge clk);
    mode     = m;
    start    = 1'b1;
    abort    = (abortAt == 0);
    core_out = rand128();
    for (int c = 1; c <= 2 * n + 5; c++) begin
      @(negedge clk);
      start = (c == extraStartAt);
      abort = (c == abortAt);
      if (c == modeChgAt) mode = modeChgVal;
      if ((abortAt > 0) && (c == abortAt + 1)) begin
        lastPass = 1'b0;
        for (int k = 0; k < 4; k++) begin
          checks += 4;
          if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL %s abort_busy cyc %0d got %0b exp 0", tag, c + k, busy);
          end
          if (core_en !== 6'b0) begin
            errors++; $display("[TB] FAIL %s abort_core_en cyc %0d got %b exp 000000", tag, c + k, core_en);
          end
          if (done !== 1'b0) begin
            errors++; $display("[TB] FAIL %s abort_done cyc %0d got %0b exp 0", tag, c + k, done);
          end
          if (pass !== 1'b0) begin
            errors++; $display("[TB] FAIL %s abort_pass cyc %0d got %0b exp 0", tag, c + k, pass);
          end
          @(negedge clk);
        end
        return;
      end
      sh    = 2 * int'(m);
      expEn = 6'b0;
      expRn = 0;
      if (c >= 2 && c <= n + 2) begin
        expEn = 6'(32'd1 << sh);
        expRn = c - 2;
      end else if (c >= n + 3 && c <= 2 * n + 3) begin
        expEn = 6'(32'd1 << (sh + 1));
        expRn = c - n - 3;
      end else if (c == 2 * n + 4) begin
        expRn = n;
      end
      expPass = (c >= 2 * n + 4) ? (encOk && decOk) : 1'b0;
      checks += 8;
      if (busy !== (c <= 2 * n + 4)) begin
        errors++; $display("[TB] FAIL %s busy cyc %0d got %0b exp %0b", tag, c, busy, (c <= 2 * n + 4));
      end
      if (core_clr !== (c == 1)) begin
        errors++; $display("[TB] FAIL %s core_clr cyc %0d got %0b exp %0b", tag, c, core_clr, (c == 1));
      end
      if (core_en !== expEn) begin
        errors++; $display("[TB] FAIL %s core_en cyc %0d got %b exp %b", tag, c, core_en, expEn);
      end
      if (round_num !== 5'(expRn)) begin
        errors++; $display("[TB] FAIL %s round_num cyc %0d got %0d exp %0d", tag, c, round_num, expRn);
      end
      if (done !== (c == 2 * n + 4)) begin
        errors++; $display("[TB] FAIL %s done cyc %0d got %0b exp %0b", tag, c, done, (c == 2 * n + 4));
      end
      if (pass !== expPass) begin
        errors++; $display("[TB] FAIL %s pass cyc %0d got %0b exp %0b", tag, c, pass, expPass);
      end
      if (err !== 1'b0) begin
        errors++; $display("[TB] FAIL %s err cyc %0d got %0b exp 0", tag, c, err);
      end
      if (display_state !== lastDisp) begin
        errors++; $display("[TB] FAIL %s display cyc %0d got %h exp %h", tag, c, display_state, lastDisp);
      end
      drv = rand128();
      if (c == n + 2) drv = ct ^ 128'(corrupt == 1);
      if (c == 2 * n + 3) drv = TB_PT ^ 128'(corrupt == 2);
      core_out = drv;
      if (c >= 2 && c <= 2 * n + 3) lastDisp = drv;
      if (c == n + 2) encOk = (corrupt != 1);
      if (c == 2 * n + 3) decOk = (corrupt != 2);
    end
    lastPass = encOk && decOk;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    mode     = 2'b00;
    core_out = '0;
    lastDisp = '0;
    lastPass = 1'b0;
    repeat (2) @(negedge clk);
    checks += 8;
    if (core_en !== 6'b0) begin errors++; $display("[TB] FAIL reset_core_en got %b exp 000000", core_en); end
    if (core_clr !== 1'b0) begin errors++; $display("[TB] FAIL reset_core_clr got %0b exp 0", core_clr); end
    if (round_num !== 5'd0) begin errors++; $display("[TB] FAIL reset_round_num got %0d exp 0", round_num); end
    if (display_state !== 128'd0) begin errors++; $display("[TB] FAIL reset_display got %h exp 0", display_state); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b exp 0", done); end
    if (pass !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass got %0b exp 0", pass); end
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %0b exp 0", err); end
    reset = 1'b1;
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy got %0b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_done got %0b exp 0", done); end
  endtask

  task automatic test_fips128();
    runSequence(2'b00, 0, -1, 0, 0, 2'b00, "fips128");
  endtask

  task automatic test_corrupt256();
    runSequence(2'b10, 1, -1, 0, 0, 2'b00, "corrupt256");
  endtask

  task automatic test_illegal_mode();
    @(negedge clk);
    mode  = 2'b11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks += 6;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL illegal_done got %0b exp 1", done); end
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err got %0b exp 1", err); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_busy got %0b exp 0", busy); end
    if (core_en !== 6'b0) begin errors++; $display("[TB] FAIL illegal_core_en got %b exp 000000", core_en); end
    if (core_clr !== 1'b0) begin errors++; $display("[TB] FAIL illegal_core_clr got %0b exp 0", core_clr); end
    if (pass !== lastPass) begin errors++; $display("[TB] FAIL illegal_pass got %0b exp %0b", pass, lastPass); end
    @(negedge clk);
    checks += 3;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL illegal_done_pulse got %0b exp 0", done); end
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err_sticky got %0b exp 1", err); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_busy_after got %0b exp 0", busy); end
    runSequence(2'b00, 0, -1, 0, 0, 2'b00, "after_illegal");
  endtask

  task automatic test_mode_change();
    runSequence(2'b01, 0, -1, 8, 5, 2'b00, "mode_change");
  endtask

  task automatic test_abort();
    runSequence(2'b00, 0, 14, 0, 0, 2'b00, "abort_dec");
    runSequence(2'b01, 0, 0, 0, 0, 2'b00, "abort_with_start");
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    mode  = 2'($urandom_range(0, 2));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    checks += 8;
    if (core_en !== 6'b0) begin errors++; $display("[TB] FAIL midreset_core_en got %b exp 000000", core_en); end
    if (core_clr !== 1'b0) begin errors++; $display("[TB] FAIL midreset_core_clr got %0b exp 0", core_clr); end
    if (round_num !== 5'd0) begin errors++; $display("[TB] FAIL midreset_round_num got %0d exp 0", round_num); end
    if (display_state !== 128'd0) begin errors++; $display("[TB] FAIL midreset_display got %h exp 0", display_state); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %0b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done got %0b exp 0", done); end
    if (pass !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pass got %0b exp 0", pass); end
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_err got %0b exp 0", err); end
    @(negedge clk);
    reset    = 1'b1;
    lastDisp = '0;
    lastPass = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks += 2;
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_done got %0b exp 0", done); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_idle_busy got %0b exp 0", busy); end
    end
    runSequence(2'b10, 0, -1, 0, 0, 2'b00, "after_midreset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      runSequence(2'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1,
                  int'($urandom_range(2, 20)), 0, 2'b00, "random");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fips128();
    test_corrupt256();
    test_illegal_mode();
    test_mode_change();
    test_abort();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
